// File: rtl/edge_sync_pkg.sv
// Shared types, parameter limits and edge-classification helper for multi_edge_sync.
package edge_sync_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_t;

  localparam int unsigned CHANNELS_MIN = 1;
  localparam int unsigned CHANNELS_MAX = 32;
  localparam int unsigned STAGES_MIN   = 2;
  localparam int unsigned STAGES_MAX   = 4;
  localparam int unsigned CNT_W_MIN    = 1;
  localparam int unsigned CNT_W_MAX    = 16;

  // Warm-up counter must reach STAGES_MAX+1.
  localparam int unsigned WARM_W = 3;

  function automatic logic edge_hit(input edge_mode_t mode, input logic last, input logic prev);
    logic hit;
    hit = 1'b0;
    case (mode)
      EDGE_RISE: hit = last & ~prev;
      EDGE_FALL: hit = ~last & prev;
      EDGE_BOTH: hit = last ^ prev;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Per-channel STAGES-deep flip-flop synchronizer, cleared by synchronous reset.
module sync_chain
  import edge_sync_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic outclk,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("sync_chain: STAGES out of range");
  end

  logic [STAGES-1:0] r_stage;

  always_ff @(posedge outclk) begin
    if (reset) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[STAGES-2:0], d};
    end
  end

  assign q = r_stage[STAGES-1];

endmodule

// File: rtl/multi_edge_sync.sv
// Multi-channel synchronizer with per-channel edge detection, sticky flags and
// saturating event counters; a shared warm-up counter masks events after reset.
module multi_edge_sync
  import edge_sync_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned STAGES   = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                      outclk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       async_sig,
  input  logic [2*CHANNELS-1:0]     edge_mode,
  input  logic [CHANNELS-1:0]       ack,
  input  logic [CHANNELS-1:0]       cnt_clr,
  output logic [CHANNELS-1:0]       out_sync_sig,
  output logic [CHANNELS-1:0]       pending,
  output logic [CHANNELS-1:0]       overflow,
  output logic [CHANNELS*CNT_W-1:0] event_count
);

  if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX ||
      CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_param
    $error("multi_edge_sync: parameter out of range");
  end

  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(STAGES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [WARM_W-1:0] r_warm;
  logic              w_armed;

  // Counts the first STAGES+1 edges after reset release, then holds.
  always_ff @(posedge outclk) begin
    if (reset) begin
      r_warm <= '0;
    end else if (r_warm != WARM_DONE) begin
      r_warm <= r_warm + WARM_W'(1);
    end
  end

  assign w_armed = (r_warm == WARM_DONE);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic             w_last;
    logic             w_event;
    logic             r_prev;
    logic             r_pulse;
    logic             r_pending;
    logic             r_overflow;
    logic [CNT_W-1:0] r_count;

    sync_chain #(.STAGES(STAGES)) u_sync (
      .outclk (outclk),
      .reset  (reset),
      .d      (async_sig[g]),
      .q      (w_last)
    );

    // Mode only gates the comparison, so changing it never fabricates an edge.
    assign w_event = w_armed &
                     edge_hit(edge_mode_t'(edge_mode[2*g +: 2]), w_last, r_prev);

    always_ff @(posedge outclk) begin
      if (reset) begin
        r_prev     <= 1'b0;
        r_pulse    <= 1'b0;
        r_pending  <= 1'b0;
        r_overflow <= 1'b0;
      end else begin
        r_prev  <= w_last;
        r_pulse <= w_event;
        if (ack[g]) begin
          r_pending  <= w_event;
          r_overflow <= 1'b0;
        end else if (w_event) begin
          r_pending <= 1'b1;
          if (r_pending) begin
            r_overflow <= 1'b1;
          end
        end
      end
    end

    // Clear wins over increment but still counts a coincident event.
    always_ff @(posedge outclk) begin
      if (reset) begin
        r_count <= '0;
      end else if (cnt_clr[g]) begin
        r_count <= CNT_W'(w_event);
      end else if (w_event && (r_count != CNT_MAX)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end

    assign out_sync_sig[g]                 = r_pulse;
    assign pending[g]                      = r_pending;
    assign overflow[g]                     = r_overflow;
    assign event_count[g*CNT_W +: CNT_W]   = r_count;
  end

endmodule

// File: tb/tb_multi_edge_sync.sv
// Self-checking bench for multi_edge_sync: directed tables/sequences plus random
// stimulus against a sample-history reference model.
module tb_multi_edge_sync;

  localparam int CH  = 4;
  localparam int ST  = 2;
  localparam int CW  = 8;
  localparam int CW2 = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [CH-1:0]    sig1 = '0, ack1 = '0, clr1 = '0;
  logic [2*CH-1:0]  mode1 = '0;
  logic [CH-1:0]    pulse1, pend1, ovf1;
  logic [CH*CW-1:0] cnt1;

  logic [CH-1:0]     sig2 = '0, ack2 = '0, clr2 = '0;
  logic [2*CH-1:0]   mode2 = '0;
  logic [CH-1:0]     pulse2, pend2, ovf2;
  logic [CH*CW2-1:0] cnt2;

  always #5 clk = ~clk;

  multi_edge_sync #(.CHANNELS(CH), .STAGES(ST), .CNT_W(CW)) u_dut (
    .outclk(clk), .reset(reset), .async_sig(sig1), .edge_mode(mode1),
    .ack(ack1), .cnt_clr(clr1), .out_sync_sig(pulse1), .pending(pend1),
    .overflow(ovf1), .event_count(cnt1)
  );

  multi_edge_sync #(.CHANNELS(CH), .STAGES(ST), .CNT_W(CW2)) u_dut_w2 (
    .outclk(clk), .reset(reset), .async_sig(sig2), .edge_mode(mode2),
    .ack(ack2), .cnt_clr(clr2), .out_sync_sig(pulse2), .pending(pend2),
    .overflow(ovf2), .event_count(cnt2)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: history of what each edge sampled, indexed by edge number.
  logic [CH-1:0] smp[$];
  int            rst_edge = 0;
  logic [CH-1:0] m_pulse = '0, m_pend = '0, m_ovf = '0;
  int            m_cnt[CH];

  task automatic model_step();
    int n;
    n = smp.size();
    if (reset) begin
      rst_edge = n;
      smp.push_back('0);
      m_pulse = '0; m_pend = '0; m_ovf = '0;
      for (int c = 0; c < CH; c++) m_cnt[c] = 0;
    end else begin
      smp.push_back(sig1);
      for (int c = 0; c < CH; c++) begin
        logic lv, pv, hit, ev;
        int   md;
        lv  = (n - ST > rst_edge)     ? smp[n - ST][c]     : 1'b0;
        pv  = (n - ST - 1 > rst_edge) ? smp[n - ST - 1][c] : 1'b0;
        md  = int'(mode1[2*c +: 2]);
        hit = (md == 0 && lv && !pv) || (md == 1 && !lv && pv) || (md == 2 && lv != pv);
        ev  = hit && (n - rst_edge >= ST + 2);
        m_pulse[c] = ev;
        if (ack1[c]) begin
          m_ovf[c]  = 1'b0;
          m_pend[c] = ev;
        end else if (ev) begin
          if (m_pend[c]) m_ovf[c] = 1'b1;
          m_pend[c] = 1'b1;
        end
        if (clr1[c])  m_cnt[c] = ev ? 1 : 0;
        else if (ev)  m_cnt[c] = (m_cnt[c] >= 255) ? 255 : m_cnt[c] + 1;
      end
    end
  endtask

  task automatic check_model();
    logic [CH*CW-1:0] ec;
    for (int c = 0; c < CH; c++) ec[c*CW +: CW] = CW'(m_cnt[c]);
    total++;
    if ({pulse1, pend1, ovf1, cnt1} !== {m_pulse, m_pend, m_ovf, ec}) begin
      bad++;
      $display("FAIL model edge=%0d pulse=%h/%h pend=%h/%h ovf=%h/%h cnt=%h/%h (got/want)",
               smp.size() - 1, pulse1, m_pulse, pend1, m_pend, ovf1, m_ovf, cnt1, ec);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic       sig;
    logic [1:0] mode;
    logic       ack;
    logic       clr;
    logic       e_pulse;
    logic       e_pend;
    logic       e_ovf;
    logic [7:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic [1:0] m, input logic a, input logic c,
                              input logic p, input logic pd, input logic o, input logic [7:0] n);
    vec_t v;
    v.sig = s; v.mode = m; v.ack = a; v.clr = c;
    v.e_pulse = p; v.e_pend = pd; v.e_ovf = o; v.e_cnt = n;
    return v;
  endfunction

  initial begin
    vec_t tbl[18];
    int   highs, rises, other, ovf_at;
    logic last_p;

    // Channel 0, mode per row; expectations are the state after that row's edge.
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 1, 1, 0, 1);
    tbl[3]  = mk(1, 2, 0, 0, 0, 1, 0, 1);
    tbl[4]  = mk(0, 2, 0, 0, 0, 1, 0, 1);
    tbl[5]  = mk(0, 2, 0, 0, 0, 1, 0, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0, 1, 0, 1);
    tbl[7]  = mk(1, 0, 0, 0, 0, 1, 0, 1);
    tbl[8]  = mk(1, 0, 0, 0, 0, 1, 0, 1);
    tbl[9]  = mk(1, 0, 0, 0, 1, 1, 1, 2);
    tbl[10] = mk(1, 0, 1, 0, 0, 0, 0, 2);
    tbl[11] = mk(1, 0, 0, 1, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tbl[16] = mk(1, 0, 1, 0, 1, 1, 0, 1);
    tbl[17] = mk(1, 0, 0, 0, 0, 1, 0, 1);

    // Reset state, then inputs held high through reset must not produce events.
    tick();
    tick();
    chk("reset_pulse", 32'(pulse1), 0);
    chk("reset_pend", 32'(pend1), 0);
    chk("reset_cnt", cnt1, 0);
    sig1 = '1;
    tick();
    tick();
    chk("reset_hi_ovf", 32'(ovf1), 0);
    reset = 1'b0;
    highs = 0;
    repeat (20) begin
      tick();
      if (pulse1 != '0 || pend1 != '0 || cnt1 != '0) highs++;
    end
    chk("high_thru_reset", 32'(highs), 0);

    // Table: single-channel timing, overflow, ack, clear.
    sig1 = '0;
    do_reset();
    repeat (6) tick();
    for (int i = 0; i < 18; i++) begin
      sig1  = {3'b000, tbl[i].sig};
      mode1 = {6'b000000, tbl[i].mode};
      ack1  = {3'b000, tbl[i].ack};
      clr1  = {3'b000, tbl[i].clr};
      tick();
      chk($sformatf("tbl%0d_pulse", i), 32'(pulse1[0]), 32'(tbl[i].e_pulse));
      chk($sformatf("tbl%0d_pend", i),  32'(pend1[0]),  32'(tbl[i].e_pend));
      chk($sformatf("tbl%0d_ovf", i),   32'(ovf1[0]),   32'(tbl[i].e_ovf));
      chk($sformatf("tbl%0d_cnt", i),   32'(cnt1[7:0]), 32'(tbl[i].e_cnt));
    end
    ack1 = '0; clr1 = '0; mode1 = '0;

    // Both-edge mode on ch1, levels held four cycles each.
    sig1 = '0;
    do_reset();
    repeat (5) tick();
    mode1 = 8'h08;
    highs = 0; rises = 0; other = 0; ovf_at = -1; last_p = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) sig1[1] = (k != 1);
      repeat (4) begin
        tick();
        if (pulse1[1]) highs++;
        if (pulse1[1] && !last_p) rises++;
        last_p = pulse1[1];
        if ((pulse1 & 4'b1101) != '0) other++;
        if (ovf1[1] && ovf_at < 0) ovf_at = highs;
      end
    end
    chk("both_highs", 32'(highs), 3);
    chk("both_rises", 32'(rises), 3);
    chk("both_cnt", 32'(cnt1[15:8]), 3);
    chk("both_ovf_at", 32'(ovf_at), 2);
    chk("both_pend", 32'(pend1[1]), 1);
    chk("both_other", 32'(other), 0);
    ack1[1] = 1'b1;
    tick();
    ack1 = '0;
    chk("ack_pend", 32'(pend1[1]), 0);
    chk("ack_ovf", 32'(ovf1[1]), 0);

    // Back-to-back events on ch2: one pulse per toggle, never merged.
    mode1[5:4] = 2'b10;
    highs = 0;
    for (int k = 0; k < 10; k++) begin
      if (k < 6) sig1[2] = ~sig1[2];
      tick();
      if (pulse1[2]) highs++;
    end
    chk("b2b_highs", 32'(highs), 6);
    chk("b2b_cnt", 32'(cnt1[23:16]), 6);

    // Ack coincident with an event while pending and overflowed on ch3.
    mode1[7:6] = 2'b10;
    sig1[3] = 1'b1;
    repeat (4) tick();
    sig1[3] = 1'b0;
    repeat (4) tick();
    chk("ch3_ovf_set", 32'(ovf1[3]), 1);
    sig1[3] = 1'b1;
    tick();
    tick();
    ack1[3] = 1'b1;
    tick();
    ack1 = '0;
    chk("ack_evt_pulse", 32'(pulse1[3]), 1);
    chk("ack_evt_pend", 32'(pend1[3]), 1);
    chk("ack_evt_ovf", 32'(ovf1[3]), 0);

    // Reset one edge after ch0 change enters stage 0; then disabled mode.
    sig1 = '0; mode1 = '0;
    do_reset();
    repeat (5) tick();
    sig1[0] = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    highs = 0;
    repeat (20) begin
      tick();
      if (pulse1[0]) highs++;
    end
    chk("abort_pulses", 32'(highs), 0);
    chk("abort_pend", 32'(pend1[0]), 0);
    mode1[1:0] = 2'b11;
    highs = 0;
    for (int k = 0; k < 4; k++) begin
      sig1[0] = ~sig1[0];
      repeat (4) begin
        tick();
        if (pulse1[0]) highs++;
      end
    end
    chk("off_pulses", 32'(highs), 0);
    chk("off_cnt", 32'(cnt1[7:0]), 0);

    // Narrow counter instance: saturation and clear-with-event.
    sig1 = '0; mode1 = '0; sig2 = '0; mode2 = '0;
    do_reset();
    repeat (5) tick();
    for (int k = 0; k < 5; k++) begin
      sig2[2] = 1'b1;
      repeat (4) tick();
      sig2[2] = 1'b0;
      repeat (4) tick();
    end
    chk("w2_sat", 32'(cnt2[5:4]), 3);
    sig2[2] = 1'b1;
    tick();
    tick();
    clr2[2] = 1'b1;
    tick();
    chk("w2_clr_evt_pulse", 32'(pulse2[2]), 1);
    chk("w2_clr_evt_cnt", 32'(cnt2[5:4]), 1);
    tick();
    chk("w2_clr_only", 32'(cnt2[5:4]), 0);
    clr2 = '0;
    chk("w2_other_cnt", 32'(cnt2[1:0]), 0);

    // Heavy both-edge activity to drive the wide counters into saturation.
    do_reset();
    mode1 = 8'hAA;
    repeat (700) begin
      sig1 = CH'($urandom);
      tick();
    end
    chk("sat_cnt", cnt1, 32'hFFFF_FFFF);

    // Random stimulus with occasional resets, acks and clears.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0)  sig1 = sig1 ^ CH'($urandom);
      if ($urandom_range(0, 49) == 0) mode1 = (2*CH)'($urandom);
      ack1 = ($urandom_range(0, 9) == 0)  ? CH'($urandom) : '0;
      clr1 = ($urandom_range(0, 29) == 0) ? CH'($urandom) : '0;
      tick();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_edge_sync.md
MULTI_EDGE_SYNC -- requirements
Module: multi_edge_sync

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent asynchronous inputs, legal range 1..32.
REQ-002 Parameter STAGES, default 2: synchronizer flip-flop depth per channel, legal range 2..4.
REQ-003 Parameter CNT_W, default 8: width of each per-channel event counter, legal range 1..16.
REQ-004 Port outclk, input, 1: sole clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port async_sig, input, CHANNELS: asynchronous level inputs, one bit per channel.
REQ-007 Port edge_mode, input, 2*CHANNELS: per-channel mode; bits [2i+1:2i] belong to channel i (00 rise, 01 fall, 10 both, 11 disabled).
REQ-008 Port ack, input, CHANNELS: clears the pending and overflow bits of channel i.
REQ-009 Port cnt_clr, input, CHANNELS: clears the event counter of channel i.
REQ-010 Port out_sync_sig, output, CHANNELS: one-cycle event pulse per channel.
REQ-011 Port pending, output, CHANNELS: sticky event-seen flag per channel.
REQ-012 Port overflow, output, CHANNELS: sticky flag, event lost while pending.
REQ-013 Port event_count, output, CHANNELS*CNT_W: saturating counters; bits [CNT_W*(i+1)-1:CNT_W*i] belong to channel i.

Function
REQ-014 Each channel SHALL pass async_sig[i] through STAGES flip-flops, followed by one history flip-flop (prev).
REQ-015 An event SHALL be detected as follows: rise when last=1 and prev=0; fall when last=0 and prev=1; both on either; none when the mode is disabled.
REQ-016 out_sync_sig[i] SHALL be registered and high for exactly one cycle per event. An input level change captured by stage 0 at edge E0 SHALL produce a pulse from edge E(STAGES) to E(STAGES+1).
REQ-017 A level held stable SHALL produce no further pulses; consecutive events SHALL produce back-to-back pulses with no merging.
REQ-018 edge_mode changes SHALL take effect on the next edge. A mode change alone SHALL never create an event.
REQ-019 On an event, pending[i] SHALL be set on the same edge that asserts the pulse.
REQ-020 On an event while pending[i] is already 1 and ack[i]=0, overflow[i] SHALL be set.
REQ-021 When ack[i] and an event occur in the same cycle, pending[i] SHALL remain 1 and overflow[i] SHALL be cleared.
REQ-022 When ack[i] occurs alone, pending[i] and overflow[i] SHALL clear on the next edge.
REQ-023 Each event SHALL increment event_count[i] by 1. The counter SHALL saturate at 2^CNT_W-1, not wrap.
REQ-024 When cnt_clr[i] and an event occur in the same cycle, the counter SHALL load 1; cnt_clr alone SHALL load 0.
REQ-025 A warm-up counter SHALL suppress all event detection (pulse, pending, overflow, count) for the first STAGES+1 edges after reset deassertion. Synchronizer and prev registers SHALL still track inputs during warm-up, so an input high through reset yields no event.
REQ-026 Channels SHALL be fully independent; activity on one channel SHALL never alter another.

Reset
REQ-027 While reset=1, the following SHALL be 0 on every edge: synchronizer stages, prev, out_sync_sig, pending, overflow, event_count, and the warm-up counter.
REQ-028 Reset asserted mid-operation SHALL abort any in-flight event; no pulse SHALL emerge from pre-reset samples.
REQ-029 Warm-up SHALL restart at each reset deassertion.

Structure
REQ-030 Package edge_sync_pkg SHALL hold the edge_mode_t enum (EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_OFF) and the parameter range limits.
REQ-031 Sub-module sync_chain (parameter STAGES; ports outclk, reset, d, q) SHALL be instantiated once per channel via generate.
REQ-032 Edge detection, flags and counters SHALL reside in multi_edge_sync; the warm-up counter SHALL be shared by all channels.

Verification
REQ-033 Defaults, mode 00 ch0: drive async_sig[0] 0->1 three cycles after warm-up ends -> out_sync_sig[0] high exactly one cycle at E2, pending[0]=1, count[0]=1.
REQ-034 Mode 10 ch1: toggle 1,0,1 each held 4 cycles -> three single pulses, count[1]=3, overflow[1]=1 after second event, ack[1] -> pending=0 and overflow=0 next cycle.
REQ-035 async_sig=all 1 during reset, release -> no pulses, pending=0, counts=0 for 20 cycles.
REQ-036 CNT_W=2: five rising events ch2 -> count[2] sticks at 3; cnt_clr with a sixth event in the same cycle -> count=1.
REQ-037 ack[3] coincident with event on ch3 (pending already 1) -> pending stays 1, overflow[3]=0.
REQ-038 Reset asserted one cycle after ch0 edge enters stage 0 -> no pulse on ch0 after release; mode 11 on ch0 -> no pulses for any toggle.
